// File: rtl/alu_exe_stage.sv
// alu_exe_stage: registered ARM data-processing execute stage with NZCV flags and a valid/ready result slot
module alu_exe_stage #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] OPCODE,
  input  logic [31:0] INA,
  input  logic [31:0] SFT_OUT,
  input  logic        SFT_COUT,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] RESULT,
  output logic        WB_EN,
  output logic [3:0]  RD,
  output logic [3:0]  FLAGS
);
  logic [3:0]  cond, op;
  logic        s, n_f, z_f, c_f, v_f;
  logic        pass, accept, logical, test;
  logic [31:0] x, y, r;
  logic        cin;
  logic [32:0] sum;
  logic        n_n, z_n, c_n, v_n;

  assign cond = OPCODE[31:28];
  assign op   = OPCODE[24:21];
  assign s    = OPCODE[20];
  assign {n_f, z_f, c_f, v_f} = FLAGS;
  assign IN_READY = !FLUSH && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;
  assign logical  = op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};
  assign test     = op[3:2] == 2'b10;

  always_comb begin
    case (cond)
      4'h0: pass = z_f;
      4'h1: pass = !z_f;
      4'h2: pass = c_f;
      4'h3: pass = !c_f;
      4'h4: pass = n_f;
      4'h5: pass = !n_f;
      4'h6: pass = v_f;
      4'h7: pass = !v_f;
      4'h8: pass = c_f && !z_f;
      4'h9: pass = !c_f || z_f;
      4'hA: pass = n_f == v_f;
      4'hB: pass = n_f != v_f;
      4'hC: pass = !z_f && (n_f == v_f);
      4'hD: pass = z_f || (n_f != v_f);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  // Subtractions are folded into an adder with an inverted operand and carry-in
  always_comb begin
    x = INA;
    y = SFT_OUT;
    cin = 1'b0;
    case (op)
      4'h2, 4'hA: begin y = ~SFT_OUT; cin = 1'b1; end
      4'h3: begin x = SFT_OUT; y = ~INA; cin = 1'b1; end
      4'h5: cin = c_f;
      4'h6: begin y = ~SFT_OUT; cin = c_f; end
      4'h7: begin x = SFT_OUT; y = ~INA; cin = c_f; end
      default: ;
    endcase
  end

  assign sum = {1'b0, x} + {1'b0, y} + {32'b0, cin};

  always_comb begin
    case (op)
      4'h0, 4'h8: r = INA & SFT_OUT;
      4'h1, 4'h9: r = INA ^ SFT_OUT;
      4'hC: r = INA | SFT_OUT;
      4'hD: r = SFT_OUT;
      4'hE: r = INA & ~SFT_OUT;
      4'hF: r = ~SFT_OUT;
      default: r = sum[31:0];
    endcase
  end

  assign n_n = r[31];
  assign z_n = r == 32'h0;
  assign c_n = logical ? SFT_COUT : sum[32];
  assign v_n = logical ? v_f : (x[31] == y[31]) && (r[31] != x[31]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      RESULT    <= 32'h0;
      WB_EN     <= 1'b0;
      RD        <= 4'h0;
      FLAGS     <= FLAGS_RESET;
    end else if (FLUSH) begin
      OUT_VALID <= 1'b0;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      RESULT    <= pass ? r : 32'h0;
      WB_EN     <= pass && !test;
      RD        <= OPCODE[15:12];
      if (pass && s) FLAGS <= {n_n, z_n, c_n, v_n};
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exe_stage.sv
// tb_alu_exe_stage: directed scoreboard bench for alu_exe_stage
module tb_alu_exe_stage;
  logic        CLK = 1'b0, RST = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, SFT_COUT = 1'b0, OUT_READY = 1'b1;
  logic [31:0] OPCODE = 32'h0, INA = 32'h0, SFT_OUT = 32'h0;
  logic        IN_READY, OUT_VALID, WB_EN;
  logic [31:0] RESULT;
  logic [3:0]  RD, FLAGS;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        chk_res;
    logic        wb;
    logic [3:0]  rd;
    logic [3:0]  flags;
  } exp_t;
  exp_t sb[$];

  alu_exe_stage #(.FLAGS_RESET(4'b0000)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPCODE(OPCODE), .INA(INA), .SFT_OUT(SFT_OUT), .SFT_COUT(SFT_COUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .WB_EN(WB_EN),
    .RD(RD), .FLAGS(FLAGS)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk(logic [3:0] cond, logic [3:0] op, logic s, logic [3:0] rd);
    return {cond, 3'b000, op, s, 4'h0, rd, 12'h0};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pops the oldest expectation and compares it with the entry just produced
  task automatic pop_check(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " valid"}, {31'h0, OUT_VALID}, 32'd1);
    chk({tag, " wb_en"}, {31'h0, WB_EN}, {31'h0, e.wb});
    if (e.chk_res) chk({tag, " result"}, RESULT, e.res);
    if (e.wb) chk({tag, " rd"}, {28'h0, RD}, {28'h0, e.rd});
    chk({tag, " flags"}, {28'h0, FLAGS}, {28'h0, e.flags});
  endtask

  task automatic issue(string tag, logic [31:0] opc, logic [31:0] a, logic [31:0] b, logic cout, exp_t e);
    OPCODE = opc; INA = a; SFT_OUT = b; SFT_COUT = cout; IN_VALID = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'h0, IN_READY}, 32'd1);
    sb.push_back(e);
    step();
    pop_check(tag);
  endtask

  initial begin
    step(); step();
    RST = 1'b0;
    #1;
    chk("rst out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst result", RESULT, 32'h0);
    chk("rst wb_en", {31'h0, WB_EN}, 32'd0);
    chk("rst rd", {28'h0, RD}, 32'd0);
    chk("rst flags", {28'h0, FLAGS}, 32'd0);
    chk("rst in_ready", {31'h0, IN_READY}, 32'd1);

    issue("adds_ovf", mk(4'hE, 4'h4, 1'b1, 4'd3), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b1, 1'b1, 4'd3, 4'b1001});
    issue("cmp_eq", mk(4'hE, 4'hA, 1'b1, 4'd0), 32'd5, 32'd5, 1'b0, '{32'h0, 1'b0, 1'b0, 4'd0, 4'b0110});
    issue("subs_neg", mk(4'hE, 4'h2, 1'b1, 4'd2), 32'd0, 32'd1, 1'b0, '{32'hFFFFFFFF, 1'b1, 1'b1, 4'd2, 4'b1000});
    issue("adds_v", mk(4'hE, 4'h4, 1'b1, 4'd1), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b1, 1'b1, 4'd1, 4'b1001});
    issue("movs", mk(4'hE, 4'hD, 1'b1, 4'd4), 32'h12345678, 32'h0, 1'b1, '{32'h0, 1'b1, 1'b1, 4'd4, 4'b0111});
    issue("adds_clr", mk(4'hE, 4'h4, 1'b1, 4'd5), 32'd1, 32'd1, 1'b0, '{32'd2, 1'b1, 1'b1, 4'd5, 4'b0000});
    issue("addeq_fail", mk(4'h0, 4'h4, 1'b1, 4'd6), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h0, 1'b1, 1'b0, 4'd6, 4'b0000});
    issue("add_al", mk(4'hE, 4'h4, 1'b1, 4'd6), 32'd1, 32'd1, 1'b0, '{32'd2, 1'b1, 1'b1, 4'd6, 4'b0000});
    issue("nv_fail", mk(4'hF, 4'h4, 1'b1, 4'd7), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h0, 1'b1, 1'b0, 4'd7, 4'b0000});
    issue("addne_nos", mk(4'h1, 4'h4, 1'b0, 4'd7), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b1, 1'b1, 4'd7, 4'b0000});
    issue("eors", mk(4'hE, 4'h1, 1'b1, 4'd15), 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, '{32'hFF00FF00, 1'b1, 1'b1, 4'd15, 4'b1010});
    issue("adds_c", mk(4'hE, 4'h4, 1'b1, 4'd8), 32'hFFFFFFFF, 32'd2, 1'b0, '{32'd1, 1'b1, 1'b1, 4'd8, 4'b0010});

    OUT_READY = 1'b0;
    OPCODE = mk(4'hE, 4'h5, 1'b1, 4'd9); INA = 32'hFFFFFFFF; SFT_OUT = 32'h0; SFT_COUT = 1'b0;
    sb.push_back('{32'h0, 1'b1, 1'b1, 4'd9, 4'b0110});
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold in_ready", {31'h0, IN_READY}, 32'd0);
      step();
      chk("hold valid", {31'h0, OUT_VALID}, 32'd1);
      chk("hold result", RESULT, 32'd1);
      chk("hold rd", {28'h0, RD}, 32'd8);
      chk("hold wb_en", {31'h0, WB_EN}, 32'd1);
      chk("hold flags", {28'h0, FLAGS}, 32'b0010);
    end
    OUT_READY = 1'b1;
    #1;
    chk("release in_ready", {31'h0, IN_READY}, 32'd1);
    step();
    pop_check("adcs_carry");
    IN_VALID = 1'b0;
    step();
    chk("drain valid", {31'h0, OUT_VALID}, 32'd0);

    issue("add_pre_flush", mk(4'hE, 4'h4, 1'b0, 4'd10), 32'd1, 32'd2, 1'b0, '{32'd3, 1'b1, 1'b1, 4'd10, 4'b0110});
    FLUSH = 1'b1;
    OPCODE = mk(4'hE, 4'h4, 1'b1, 4'd11); INA = 32'h7FFFFFFF; SFT_OUT = 32'h1;
    #1;
    chk("flush in_ready", {31'h0, IN_READY}, 32'd0);
    step();
    chk("flush valid", {31'h0, OUT_VALID}, 32'd0);
    chk("flush flags", {28'h0, FLAGS}, 32'b0110);
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    step();
    chk("post flush valid", {31'h0, OUT_VALID}, 32'd0);

    issue("adds_pre_rst", mk(4'hE, 4'h4, 1'b1, 4'd12), 32'h7FFFFFFF, 32'h1, 1'b0, '{32'h80000000, 1'b1, 1'b1, 4'd12, 4'b1001});
    RST = 1'b1;
    step();
    chk("rst2 valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst2 flags", {28'h0, FLAGS}, 32'd0);
    chk("rst2 result", RESULT, 32'h0);
    RST = 1'b0;
    IN_VALID = 1'b0;
    step();
    chk("sb drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exe_stage.md
# alu_exe_stage

Registered execute stage that consumes the barrel-shifter operand (`SFT_OUT`/`SFT_COUT`) and the first operand, and performs the ARM data-processing operation. It evaluates the instruction condition code, updates the NZCV flags register and presents a one-entry registered result to writeback through a valid/ready handshake. It sits directly downstream of the shifter unit and directly upstream of register writeback.

## Interface
- `FLAGS_RESET`, 4'b0000, NZCV value loaded on reset.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `FLUSH`  in  1  discard the held entry and refuse input this cycle.
- `IN_VALID`  in  1  upstream presents an instruction.
- `IN_READY`  out  1  stage accepts this cycle.
- `OPCODE`  in  32  instruction word: cond [31:28], op [24:21], S [20], Rd [15:12].
- `INA`  in  32  Rn operand.
- `SFT_OUT`  in  32  shifter operand 2.
- `SFT_COUT`  in  1  shifter carry-out.
- `OUT_VALID`  out  1  result entry held.
- `OUT_READY`  in  1  downstream consumes the entry.
- `RESULT`  out  32  ALU result.
- `WB_EN`  out  1  write `RESULT` to `RD`.
- `RD`  out  4  destination register.
- `FLAGS`  out  4  current NZCV register.

## Operation
- Accept when `IN_VALID && IN_READY`; `IN_READY = !FLUSH && (!OUT_VALID || OUT_READY)`.
- Condition is checked against the current `FLAGS` using the standard ARM codes EQ…AL. `cond == 4'b1111` never passes.
- Condition fails: the entry is still produced with `WB_EN=0` and `RESULT=0`, and flags are unchanged.
- A = `INA`, B = `SFT_OUT`, Cf = `FLAGS[1]`. Arithmetic is 33-bit, and C is bit 32 of the sum.
  - ADD = A+B.
  - ADC = A+B+Cf.
  - SUB/CMP = A+~B+1.
  - SBC = A+~B+Cf.
  - RSB = B+~A+1.
  - RSC = B+~A+Cf.
  - CMN = A+B.
- V for arithmetic ops = (x[31]==y[31]) && (r[31]!=x[31]), where x and y are the two summands.
- Logical ops:
  - AND/TST = A&B.
  - EOR/TEQ = A^B.
  - ORR = A|B.
  - MOV = B.
  - BIC = A&~B.
  - MVN = ~B.
  - Logical ops set C = `SFT_COUT` and leave V unchanged.
- N = r[31]; Z = (r[31:0]==0).
- Flag write happens on the accept edge when the condition passes and S=1. If S=0, flags are unchanged.
- TST/TEQ/CMP/CMN: `WB_EN=0`; flags are written only when S=1.
- All other ops that pass the condition: `WB_EN=1`, `RD = OPCODE[15:12]`. Rd=15 gets no special treatment.
- An accepted instruction's flag update is visible to the next accepted instruction.

## Timing
- Reset: `OUT_VALID=0`, `RESULT=0`, `WB_EN=0`, `RD=0`, `FLAGS=FLAGS_RESET`. `IN_READY=1` after reset unless `FLUSH` is high.
- Latency: an instruction accepted at edge k is visible on `RESULT`/`WB_EN`/`RD` with `OUT_VALID=1` after edge k, and `FLAGS` updates at edge k.
- Hold: while `OUT_VALID && !OUT_READY`, all outputs are stable and no flag update occurs.
- Full and consumed in the same cycle: the new entry replaces the old one at the same edge, giving throughput of 1 per cycle.
- Consumed with no new input: `OUT_VALID` falls to 0 at the next edge.
- `FLUSH`: at the next edge `OUT_VALID=0`; the input that cycle is not accepted and `FLAGS` is unchanged. A flush of an already-accepted entry does not roll back its flag update.
- `RST` has priority over everything. Any held entry is discarded and FLAGS returns to `FLAGS_RESET` at the reset edge.
- Outputs are fully registered; `IN_READY` is combinational from `OUT_VALID`, `OUT_READY` and `FLUSH`.

## Test plan
- ADDS, AL, A=0x7FFFFFFF, B=0x00000001, Rd=3 -> next cycle `RESULT=0x80000000`, `WB_EN=1`, `RD=3`, `FLAGS=4'b1001`.
- CMP (S=1), A=5, B=5 -> `WB_EN=0`, `FLAGS=4'b0110`. Then SUBS 0-1 -> `RESULT=0xFFFFFFFF`, `FLAGS=4'b1000`.
- MOVS with `SFT_OUT=0`, `SFT_COUT=1`, prior V=1 -> `RESULT=0`, `FLAGS=4'b0111`.
- With Z=0, ADDEQ with S=1 -> `OUT_VALID=1`, `WB_EN=0`, `FLAGS` unchanged. The same instruction with AL produces `WB_EN=1`.
- Backpressure: hold `OUT_READY=0` for 3 cycles with `IN_VALID=1` and ADDS queued.
  - Required: `IN_READY=0`, outputs stable and `FLAGS` unchanged.
  - On release, back-to-back ADCS sees the carry from the prior instruction: 0xFFFFFFFF+0 with Cf=1 gives `RESULT=0`, `FLAGS=4'b0110`.
- `FLUSH` with `IN_VALID=1` -> `OUT_VALID=0` next cycle and `FLAGS` unchanged. `RST` asserted mid-stream -> `OUT_VALID=0` and `FLAGS=FLAGS_RESET` after one edge.
